painterengine_gpu_dma_reader_p: RTL and testbench
=================================================

PAINTERENGINE_GPU_DMA_READER_P -- requirements
Module: painterengine_gpu_dma_reader_p

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of one-hot routed consumer channels (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI read data width in bits (32, 64 or 128); BYTES = DATA_WIDTH/8.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per AXI burst (power of 2, 1..256).
REQ-004 SHALL have parameter TIMEOUT_BITS, default 19, width of the stall timeout counter.
REQ-005 SHALL provide these ports, one per line:
 i_wire_clock  in  1  clock, all logic on rising edge
 i_wire_resetn  in  1  reset, asynchronous, active-low
 i_wire_start  in  1  launch pulse; router/address/length sampled when accepted
 i_wire_abort  in  1  request to stop the transfer at the next burst boundary
 i_wire_router  in  CHANNELS  one-hot channel select
 i_wire_address  in  CHANNELS*32  per-channel byte start address
 i_wire_length  in  CHANNELS*32  per-channel transfer length in beats
 o_wire_data  out  CHANNELS*DATA_WIDTH  per-channel read data
 o_wire_data_valid  out  CHANNELS  per-channel data valid
 i_wire_data_next  in  CHANNELS  per-channel consumer ready
 o_wire_busy  out  1  transfer in progress
 o_wire_done  out  1  transfer completed successfully
 o_wire_error  out  1  transfer ended in error
 o_wire_error_type  out  3  error code
 o_wire_M_AXI_ARADDR/ARLEN/ARSIZE/ARBURST  out  32/8/3/2  read address, beats-1, log2(BYTES), 2'b01 INCR
 o_wire_M_AXI_ARID/ARLOCK/ARCACHE/ARPROT/ARQOS  out  1/1/4/3/4  constants 0/0/4'b0010/0/0
 o_wire_M_AXI_ARVALID  out 1; i_wire_M_AXI_ARREADY  in 1  AR handshake
 i_wire_M_AXI_RDATA/RRESP/RLAST/RVALID/RID  in  DATA_WIDTH/2/1/1/1  read data channel
 o_wire_M_AXI_RREADY  out  1  read data ready

Function
REQ-006 SHALL implement states IDLE, CHECK, CALC, ADDR, DATA, DRAIN, DONE, ERROR.
REQ-007 SHALL accept i_wire_start only in IDLE, DONE or ERROR; acceptance latches channel index, address and length of the routed channel, clears error_type and goes to CHECK.
REQ-008 SHALL in CHECK go to ERROR with code 001 if router is not one-hot; else code 010 if address low log2(BYTES) bits are nonzero, length is 0, or address+length*BYTES exceeds 2^32; else go to CALC with offset 0.
REQ-009 SHALL in CALC compute burst = min(MAX_BURST, length-offset, (4096-(cur_addr mod 4096))/BYTES), cur_addr = address+offset*BYTES, then enter ADDR.
REQ-010 SHALL drive ARVALID=1 from ADDR entry, hold ARADDR/ARLEN stable until ARREADY, then deassert ARVALID and enter DATA; first ARVALID exactly 3 cycles after start accepted.
REQ-011 SHALL in DATA drive RREADY = i_wire_data_next[sel], route RDATA/RVALID to the selected channel only, and drive all other channels' data and valid to 0; outside DATA/DRAIN RREADY=0 and all valid=0.
REQ-012 SHALL count accepted beats; RLAST on last expected beat -> offset += burst, then DONE if offset = length else CALC; RLAST mismatch (early or missing on last beat) -> ERROR code 101.
REQ-013 SHALL on an accepted beat with RRESP!=0 record code 110 and enter DRAIN.
REQ-014 SHALL latch i_wire_abort whenever busy; latched abort takes effect after the current burst's RLAST (or before issuing AR if in CALC), ending in ERROR code 111.
REQ-015 SHALL in DRAIN hold RREADY=1, suppress all data_valid, and enter ERROR with the recorded code on RLAST.
REQ-016 SHALL run a stall counter incremented each cycle in ADDR without ARREADY or in DATA without RVALID, cleared on every handshake and state change; consumer back-pressure SHALL NOT count; bit TIMEOUT_BITS-1 set -> ERROR code 011 (ADDR) or 100 (DATA).
REQ-017 SHALL hold DONE and ERROR until the next accepted start; o_wire_done = (state==DONE), o_wire_error = (state==ERROR), o_wire_busy = state in CHECK..DRAIN.
REQ-018 SHALL use error codes 000 ok, 001 router, 010 address, 011 AR timeout, 100 R timeout, 101 protocol, 110 slave response, 111 aborted.

Reset
REQ-019 SHALL on reset assertion go to IDLE, clear all registers, and drive ARVALID=0, RREADY=0, all data/valid 0, busy/done/error 0, error_type 000, regardless of AXI transfers in flight.

Verification
REQ-020 Ch2 start, addr 0x1000, len 40, DATA_WIDTH 32, MAX_BURST 16 -> ARLEN 15,15,7 at 0x1000/0x1040/0x1080; 40 beats on ch2 only; done=1.
REQ-021 addr 0x0FF8, len 8, 32-bit -> bursts ARLEN 1 at 0x0FF8, ARLEN 5 at 0x1000 (4 KB split); done.
REQ-022 router 4'b0110 -> error=1, type 001, no ARVALID; addr 0x1002 -> type 010.
REQ-023 RRESP=2'b10 on beat 3 of 16 -> remaining beats drained with RREADY=1 and valid=0; error type 110 after RLAST.
REQ-024 abort pulse mid-burst 1 of 3 -> burst 1 completes, no further AR, error type 111; ARREADY held low 2^18 cycles -> type 011.
REQ-025 reset asserted in DATA -> all outputs at reset values next cycle; subsequent start runs a clean transfer to done.

Source files
------------

// File: rtl/painterengine_gpu_dma_reader_p_if.sv
// AXI4 read-only (AR + R) channel bundle between the DMA reader and its memory slave.
interface painterengine_gpu_dma_reader_p_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [31:0]           o_wire_M_AXI_ARADDR;
   logic [7:0]            o_wire_M_AXI_ARLEN;
   logic [2:0]            o_wire_M_AXI_ARSIZE;
   logic [1:0]            o_wire_M_AXI_ARBURST;
   logic                  o_wire_M_AXI_ARID;
   logic                  o_wire_M_AXI_ARLOCK;
   logic [3:0]            o_wire_M_AXI_ARCACHE;
   logic [2:0]            o_wire_M_AXI_ARPROT;
   logic [3:0]            o_wire_M_AXI_ARQOS;
   logic                  o_wire_M_AXI_ARVALID;
   logic                  i_wire_M_AXI_ARREADY;
   logic [DATA_WIDTH-1:0] i_wire_M_AXI_RDATA;
   logic [1:0]            i_wire_M_AXI_RRESP;
   logic                  i_wire_M_AXI_RLAST;
   logic                  i_wire_M_AXI_RVALID;
   logic                  i_wire_M_AXI_RID;
   logic                  o_wire_M_AXI_RREADY;

   modport master (
      output o_wire_M_AXI_ARADDR, o_wire_M_AXI_ARLEN, o_wire_M_AXI_ARSIZE, o_wire_M_AXI_ARBURST,
             o_wire_M_AXI_ARID, o_wire_M_AXI_ARLOCK, o_wire_M_AXI_ARCACHE, o_wire_M_AXI_ARPROT,
             o_wire_M_AXI_ARQOS, o_wire_M_AXI_ARVALID, o_wire_M_AXI_RREADY,
      input  i_wire_M_AXI_ARREADY, i_wire_M_AXI_RDATA, i_wire_M_AXI_RRESP, i_wire_M_AXI_RLAST,
             i_wire_M_AXI_RVALID, i_wire_M_AXI_RID
   );

   modport slave (
      input  o_wire_M_AXI_ARADDR, o_wire_M_AXI_ARLEN, o_wire_M_AXI_ARSIZE, o_wire_M_AXI_ARBURST,
             o_wire_M_AXI_ARID, o_wire_M_AXI_ARLOCK, o_wire_M_AXI_ARCACHE, o_wire_M_AXI_ARPROT,
             o_wire_M_AXI_ARQOS, o_wire_M_AXI_ARVALID, o_wire_M_AXI_RREADY,
      output i_wire_M_AXI_ARREADY, i_wire_M_AXI_RDATA, i_wire_M_AXI_RRESP, i_wire_M_AXI_RLAST,
             i_wire_M_AXI_RVALID, i_wire_M_AXI_RID
   );
endinterface

// File: rtl/painterengine_gpu_dma_reader_p.sv
// Multi-channel AXI4 burst read DMA: splits a per-channel transfer into 4 KB-safe INCR bursts
// and streams the returned beats to the one-hot selected consumer channel.
module painterengine_gpu_dma_reader_p #(
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned MAX_BURST    = 16,
   parameter int unsigned TIMEOUT_BITS = 19
) (
   input  logic                           i_wire_clock,
   input  logic                           i_wire_resetn,
   input  logic                           i_wire_start,
   input  logic                           i_wire_abort,
   input  logic [CHANNELS-1:0]            i_wire_router,
   input  logic [CHANNELS*32-1:0]         i_wire_address,
   input  logic [CHANNELS*32-1:0]         i_wire_length,
   output logic [CHANNELS*DATA_WIDTH-1:0] o_wire_data,
   output logic [CHANNELS-1:0]            o_wire_data_valid,
   input  logic [CHANNELS-1:0]            i_wire_data_next,
   output logic                           o_wire_busy,
   output logic                           o_wire_done,
   output logic                           o_wire_error,
   output logic [2:0]                     o_wire_error_type,
   painterengine_gpu_dma_reader_p_if.master m_axi
);
   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned SIZE  = $clog2(BYTES);
   localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned BW    = $clog2(MAX_BURST) + 1;

   localparam logic [2:0] ERR_NONE    = 3'b000;
   localparam logic [2:0] ERR_ROUTER  = 3'b001;
   localparam logic [2:0] ERR_ADDR    = 3'b010;
   localparam logic [2:0] ERR_AR_TMO  = 3'b011;
   localparam logic [2:0] ERR_R_TMO   = 3'b100;
   localparam logic [2:0] ERR_PROTO   = 3'b101;
   localparam logic [2:0] ERR_SLAVE   = 3'b110;
   localparam logic [2:0] ERR_ABORT   = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_CALC, S_ADDR, S_DATA, S_DRAIN, S_DONE, S_ERROR
   } state_t;

   state_t                  state_q;
   logic [CHANNELS-1:0]     router_q;
   logic [SEL_W-1:0]        sel_q;
   logic [31:0]             address_q;
   logic [31:0]             length_q;
   logic [31:0]             offset_q;
   logic [31:0]             cur_addr_q;
   logic [BW-1:0]           burst_q;
   logic [BW-1:0]           beat_q;
   logic [31:0]             araddr_q;
   logic [7:0]              arlen_q;
   logic                    arvalid_q;
   logic [TIMEOUT_BITS-1:0] stall_q;
   logic [2:0]              err_q;
   logic                    abort_q;

   logic [SEL_W-1:0] sel_c;
   logic [31:0]      remain_c;
   logic [31:0]      room_c;
   logic [31:0]      burst_c;
   logic [63:0]      end_c;
   logic [12:0]      page_left_c;
   logic             bad_range_c;
   logic             last_c;
   logic             rready_c;
   logic             beat_c;
   logic             unused_rid;

   // Lowest set router bit picks the channel whose address/length get latched.
   always_comb begin
      sel_c = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (i_wire_router[i]) sel_c = SEL_W'(i);
      end
   end

   // Burst sizing: bounded by MAX_BURST, remaining beats, and the distance to the next 4 KB page.
   always_comb begin
      remain_c    = length_q - offset_q;
      page_left_c = 13'h1000 - {1'b0, cur_addr_q[11:0]};
      room_c      = 32'(page_left_c >> SIZE);
      burst_c     = 32'(MAX_BURST);
      if (remain_c < burst_c) burst_c = remain_c;
      if (room_c < burst_c)   burst_c = room_c;
      end_c       = 64'(address_q) + (64'(length_q) << SIZE);
      bad_range_c = (address_q[SIZE-1:0] != '0) || (length_q == 32'd0) ||
                    (end_c > 64'h1_0000_0000);
   end

   assign rready_c = (state_q == S_DRAIN) || ((state_q == S_DATA) && i_wire_data_next[sel_q]);
   assign beat_c   = m_axi.i_wire_M_AXI_RVALID && rready_c;
   assign last_c   = (beat_q == burst_q - BW'(1));

   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         state_q    <= S_IDLE;
         router_q   <= '0;
         sel_q      <= '0;
         address_q  <= '0;
         length_q   <= '0;
         offset_q   <= '0;
         cur_addr_q <= '0;
         burst_q    <= '0;
         beat_q     <= '0;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arvalid_q  <= 1'b0;
         stall_q    <= '0;
         err_q      <= ERR_NONE;
         abort_q    <= 1'b0;
      end else begin
         if (o_wire_busy && i_wire_abort) abort_q <= 1'b1;
         unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (i_wire_start) begin
                  router_q  <= i_wire_router;
                  sel_q     <= sel_c;
                  address_q <= i_wire_address[32'(sel_c)*32 +: 32];
                  length_q  <= i_wire_length[32'(sel_c)*32 +: 32];
                  err_q     <= ERR_NONE;
                  abort_q   <= 1'b0;
                  state_q   <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (!$onehot(router_q)) begin
                  err_q   <= ERR_ROUTER;
                  state_q <= S_ERROR;
               end else if (bad_range_c) begin
                  err_q   <= ERR_ADDR;
                  state_q <= S_ERROR;
               end else begin
                  offset_q   <= '0;
                  cur_addr_q <= address_q;
                  state_q    <= S_CALC;
               end
            end
            S_CALC: begin
               if (abort_q) begin
                  err_q   <= ERR_ABORT;
                  state_q <= S_ERROR;
               end else begin
                  burst_q   <= BW'(burst_c);
                  araddr_q  <= cur_addr_q;
                  arlen_q   <= 8'(burst_c - 32'd1);
                  arvalid_q <= 1'b1;
                  stall_q   <= '0;
                  state_q   <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (m_axi.i_wire_M_AXI_ARREADY) begin
                  arvalid_q <= 1'b0;
                  beat_q    <= '0;
                  stall_q   <= '0;
                  state_q   <= S_DATA;
               end else if (stall_q[TIMEOUT_BITS-1]) begin
                  arvalid_q <= 1'b0;
                  err_q     <= ERR_AR_TMO;
                  state_q   <= S_ERROR;
               end else begin
                  stall_q <= stall_q + TIMEOUT_BITS'(1);
               end
            end
            S_DATA: begin
               if (beat_c) begin
                  stall_q <= '0;
                  beat_q  <= beat_q + BW'(1);
                  if (m_axi.i_wire_M_AXI_RRESP != 2'b00) begin
                     err_q   <= ERR_SLAVE;
                     state_q <= m_axi.i_wire_M_AXI_RLAST ? S_ERROR : S_DRAIN;
                  end else if (m_axi.i_wire_M_AXI_RLAST != last_c) begin
                     err_q   <= ERR_PROTO;
                     state_q <= S_ERROR;
                  end else if (last_c) begin
                     offset_q   <= offset_q + 32'(burst_q);
                     cur_addr_q <= cur_addr_q + (32'(burst_q) << SIZE);
                     if (abort_q) begin
                        err_q   <= ERR_ABORT;
                        state_q <= S_ERROR;
                     end else if (offset_q + 32'(burst_q) == length_q) begin
                        state_q <= S_DONE;
                     end else begin
                        state_q <= S_CALC;
                     end
                  end
               end else if (!m_axi.i_wire_M_AXI_RVALID) begin
                  // Only a silent slave counts toward the timeout, not consumer back-pressure.
                  if (stall_q[TIMEOUT_BITS-1]) begin
                     err_q   <= ERR_R_TMO;
                     state_q <= S_ERROR;
                  end else begin
                     stall_q <= stall_q + TIMEOUT_BITS'(1);
                  end
               end else begin
                  stall_q <= '0;
               end
            end
            S_DRAIN: begin
               if (m_axi.i_wire_M_AXI_RVALID && m_axi.i_wire_M_AXI_RLAST) state_q <= S_ERROR;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Returned beats go to the selected channel only, and only while genuinely streaming.
   always_comb begin
      o_wire_data       = '0;
      o_wire_data_valid = '0;
      if (state_q == S_DATA) begin
         o_wire_data[32'(sel_q)*DATA_WIDTH +: DATA_WIDTH] = m_axi.i_wire_M_AXI_RDATA;
         o_wire_data_valid[sel_q]                         = m_axi.i_wire_M_AXI_RVALID;
      end
   end

   assign o_wire_busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
   assign o_wire_done       = (state_q == S_DONE);
   assign o_wire_error      = (state_q == S_ERROR);
   assign o_wire_error_type = err_q;

   assign m_axi.o_wire_M_AXI_ARADDR  = araddr_q;
   assign m_axi.o_wire_M_AXI_ARLEN   = arlen_q;
   assign m_axi.o_wire_M_AXI_ARSIZE  = 3'(SIZE);
   assign m_axi.o_wire_M_AXI_ARBURST = 2'b01;
   assign m_axi.o_wire_M_AXI_ARID    = 1'b0;
   assign m_axi.o_wire_M_AXI_ARLOCK  = 1'b0;
   assign m_axi.o_wire_M_AXI_ARCACHE = 4'b0010;
   assign m_axi.o_wire_M_AXI_ARPROT  = 3'b000;
   assign m_axi.o_wire_M_AXI_ARQOS   = 4'b0000;
   assign m_axi.o_wire_M_AXI_ARVALID = arvalid_q;
   assign m_axi.o_wire_M_AXI_RREADY  = rready_c;

   assign unused_rid = m_axi.i_wire_M_AXI_RID;
endmodule

// File: tb/tb_painterengine_gpu_dma_reader_p.sv
// Directed + randomized bench for the DMA reader: a behavioural burst planner and AXI slave model
// predict bursts, routed beats and the final done/error outcome of each transfer.
module tb_painterengine_gpu_dma_reader_p;
   localparam int unsigned CH = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned MB = 16;
   localparam int unsigned TB = 8;

   logic              clk;
   logic              resetn;
   logic              start, abort_p;
   logic [CH-1:0]     router, data_next, valid;
   logic [CH*32-1:0]  address, length;
   logic [CH*DW-1:0]  data;
   logic              busy, done, error;
   logic [2:0]        etype;

   painterengine_gpu_dma_reader_p_if #(.DATA_WIDTH(DW)) axi ();

   painterengine_gpu_dma_reader_p #(
      .CHANNELS(CH), .DATA_WIDTH(DW), .MAX_BURST(MB), .TIMEOUT_BITS(TB)
   ) dut (
      .i_wire_clock(clk), .i_wire_resetn(resetn), .i_wire_start(start), .i_wire_abort(abort_p),
      .i_wire_router(router), .i_wire_address(address), .i_wire_length(length),
      .o_wire_data(data), .o_wire_data_valid(valid), .i_wire_data_next(data_next),
      .o_wire_busy(busy), .o_wire_done(done), .o_wire_error(error), .o_wire_error_type(etype),
      .m_axi(axi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic [1:0]    resp;
   } beat_t;

   beat_t rq[$];
   int    tests = 0;
   int    fails = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic run_xfer(input string name, input logic [CH-1:0] rt, input int ch,
                           input logic [31:0] addr, input logic [31:0] len,
                           input int err_beat, input int abort_beat,
                           input bit ar_block, input bit r_block, input int reset_beat);
      longint ba[$];
      longint bl[$];
      longint off, a, room, b, cum;
      int     exp_code, exp_ars, exp_beats, exp_drain, idx;
      int     ar_hs, ar_bad, delivered, drained, route_bad, data_bad, pushed;
      int     first_ar, hs_iter, fin;
      bit     drain, abort_sent, rst_hit;
      beat_t  bt;

      // Reference: plan the bursts and the outcome straight from the transfer rules.
      exp_code = 0;
      if ($countones(rt) != 1) exp_code = 1;
      else if (addr[1:0] != 2'b00 || len == 0 ||
               longint'(addr) + longint'(len) * 4 > 64'h1_0000_0000) exp_code = 2;
      if (exp_code == 0) begin
         off = 0;
         while (off < longint'(len)) begin
            a    = longint'(addr) + off * 4;
            room = (4096 - (a % 4096)) / 4;
            b    = MB;
            if (longint'(len) - off < b) b = longint'(len) - off;
            if (room < b) b = room;
            ba.push_back(a);
            bl.push_back(b);
            off += b;
         end
      end
      exp_ars = 0; exp_beats = 0; exp_drain = 0; idx = 0; cum = 0;
      if (exp_code != 0) begin
      end else if (ar_block) exp_code = 3;
      else if (r_block) begin exp_code = 4; exp_ars = 1; end
      else if (err_beat > 0 || abort_beat > 0) begin
         for (int i = 0; i < bl.size(); i++) begin
            cum += bl[i];
            idx = i;
            if (cum >= longint'(err_beat + abort_beat)) break;
         end
         exp_ars = idx + 1;
         if (err_beat > 0) begin
            exp_code = 6; exp_beats = err_beat; exp_drain = int'(cum) - err_beat;
         end else begin
            exp_code = 7; exp_beats = int'(cum);
         end
      end else begin
         exp_ars = bl.size(); exp_beats = int'(len);
      end

      rq.delete();
      for (int j = 0; j < CH; j++) begin
         address[j*32 +: 32] = $urandom;
         length[j*32 +: 32]  = $urandom;
      end
      address[ch*32 +: 32] = addr;
      length[ch*32 +: 32]  = len;
      router = rt;
      ar_hs = 0; ar_bad = 0; delivered = 0; drained = 0; route_bad = 0; data_bad = 0; pushed = 0;
      first_ar = -1; hs_iter = -1; fin = -1; drain = 0; abort_sent = 0; rst_hit = 0;

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (reset_beat > 0 && delivered >= reset_beat) begin
            resetn = 1'b0;
            start = 1'b0; abort_p = 1'b0;
            axi.i_wire_M_AXI_ARREADY = 1'b0;
            axi.i_wire_M_AXI_RVALID  = 1'b0;
            #1;
            check({name, "_rst_ctrl"}, longint'({axi.o_wire_M_AXI_ARVALID, axi.o_wire_M_AXI_RREADY,
                  busy, done, error, etype, valid}), 0);
            check({name, "_rst_data"}, longint'(data != '0), 0);
            @(negedge clk);
            resetn = 1'b1;
            rst_hit = 1;
            break;
         end
         start   = (i == 0);
         abort_p = (abort_beat > 0 && !abort_sent && delivered >= abort_beat);
         if (abort_p) abort_sent = 1;
         axi.i_wire_M_AXI_ARREADY = !ar_block && ($urandom_range(0, 2) != 0);
         if (!r_block && rq.size() > 0 && $urandom_range(0, 3) != 0) begin
            axi.i_wire_M_AXI_RVALID = 1'b1;
            axi.i_wire_M_AXI_RDATA  = rq[0].data;
            axi.i_wire_M_AXI_RLAST  = rq[0].last;
            axi.i_wire_M_AXI_RRESP  = rq[0].resp;
         end else begin
            axi.i_wire_M_AXI_RVALID = 1'b0;
            axi.i_wire_M_AXI_RDATA  = $urandom;
            axi.i_wire_M_AXI_RLAST  = 1'b0;
            axi.i_wire_M_AXI_RRESP  = 2'b00;
         end
         data_next = CH'($urandom);
         if ($urandom_range(0, 3) != 0) data_next[ch] = 1'b1;
         #1;
         if (i > 0 && (done || error)) begin fin = i; break; end
         if (axi.o_wire_M_AXI_ARVALID && first_ar < 0) first_ar = i;
         for (int j = 0; j < CH; j++)
            if (j != ch && (valid[j] || data[j*DW +: DW] != '0)) route_bad++;
         if (!axi.i_wire_M_AXI_RVALID && valid[ch]) route_bad++;
         if (axi.i_wire_M_AXI_RVALID && drain && (valid[ch] || !axi.o_wire_M_AXI_RREADY)) route_bad++;
         if (axi.i_wire_M_AXI_RVALID && !drain &&
             (!valid[ch] || axi.o_wire_M_AXI_RREADY != data_next[ch])) route_bad++;
         if (axi.o_wire_M_AXI_ARVALID && axi.i_wire_M_AXI_ARREADY) begin
            if (ar_hs >= ba.size() || longint'(axi.o_wire_M_AXI_ARADDR) != ba[ar_hs] ||
                longint'(axi.o_wire_M_AXI_ARLEN) != bl[ar_hs] - 1 ||
                axi.o_wire_M_AXI_ARSIZE != 3'd2 || axi.o_wire_M_AXI_ARBURST != 2'b01) ar_bad++;
            for (int k = 0; k <= int'(axi.o_wire_M_AXI_ARLEN); k++) begin
               pushed++;
               bt.data = $urandom;
               bt.last = (k == int'(axi.o_wire_M_AXI_ARLEN));
               bt.resp = (pushed == err_beat) ? 2'b10 : 2'b00;
               rq.push_back(bt);
            end
            ar_hs++;
            hs_iter = i;
         end
         if (axi.i_wire_M_AXI_RVALID && axi.o_wire_M_AXI_RREADY) begin
            if (drain) drained++;
            else begin
               delivered++;
               if (data[ch*DW +: DW] !== rq[0].data) data_bad++;
               if (rq[0].resp != 2'b00) drain = 1;
            end
            void'(rq.pop_front());
         end
      end
      start = 1'b0; abort_p = 1'b0;
      axi.i_wire_M_AXI_ARREADY = 1'b0;
      axi.i_wire_M_AXI_RVALID  = 1'b0;

      if (!rst_hit) begin
         check({name, "_finished"}, longint'(fin > 0), 1);
         check({name, "_done"}, longint'(done), longint'(exp_code == 0));
         check({name, "_error"}, longint'(error), longint'(exp_code != 0));
         check({name, "_err_type"}, longint'(etype), exp_code);
         check({name, "_busy_end"}, longint'(busy), 0);
         check({name, "_ar_count"}, ar_hs, exp_ars);
         check({name, "_ar_fields"}, ar_bad, 0);
         check({name, "_beats"}, delivered, exp_beats);
         check({name, "_drained"}, drained, exp_drain);
         check({name, "_routing"}, route_bad, 0);
         check({name, "_data"}, data_bad, 0);
         if (exp_code == 1 || exp_code == 2) check({name, "_no_arvalid"}, first_ar, -1);
         else check({name, "_ar_latency"}, first_ar, 3);
         if (exp_code == 3) check({name, "_ar_tmo_cycles"}, fin - first_ar, (1 << (TB - 1)) + 1);
         if (exp_code == 4) check({name, "_r_tmo_cycles"}, fin - hs_iter, (1 << (TB - 1)) + 2);
      end
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; abort_p = 1'b0;
      router = '0; address = '0; length = '0; data_next = '0;
      axi.i_wire_M_AXI_ARREADY = 1'b0;
      axi.i_wire_M_AXI_RVALID  = 1'b0;
      axi.i_wire_M_AXI_RDATA   = '0;
      axi.i_wire_M_AXI_RLAST   = 1'b0;
      axi.i_wire_M_AXI_RRESP   = 2'b00;
      axi.i_wire_M_AXI_RID     = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_ctrl", longint'({axi.o_wire_M_AXI_ARVALID, axi.o_wire_M_AXI_RREADY,
            busy, done, error, etype, valid}), 0);
      check("reset_data", longint'(data != '0), 0);
      check("ar_consts", longint'({axi.o_wire_M_AXI_ARID, axi.o_wire_M_AXI_ARLOCK,
            axi.o_wire_M_AXI_ARCACHE, axi.o_wire_M_AXI_ARPROT, axi.o_wire_M_AXI_ARQOS}),
            longint'({1'b0, 1'b0, 4'b0010, 3'b000, 4'b0000}));
      resetn = 1'b1;

      run_xfer("ch2_len40",   4'b0100, 2, 32'h0000_1000, 32'd40, 0, 0, 0, 0, 0);
      run_xfer("page_split",  4'b0001, 0, 32'h0000_0FF8, 32'd8,  0, 0, 0, 0, 0);
      run_xfer("router_bad",  4'b0110, 1, 32'h0000_1000, 32'd8,  0, 0, 0, 0, 0);
      run_xfer("addr_unalig", 4'b1000, 3, 32'h0000_1002, 32'd8,  0, 0, 0, 0, 0);
      run_xfer("len_zero",    4'b0010, 1, 32'h0000_2000, 32'd0,  0, 0, 0, 0, 0);
      run_xfer("top_exact",   4'b0010, 1, 32'hFFFF_FFF0, 32'd4,  0, 0, 0, 0, 0);
      run_xfer("top_over",    4'b0010, 1, 32'hFFFF_FFF0, 32'd5,  0, 0, 0, 0, 0);
      run_xfer("slverr_b3",   4'b0001, 0, 32'h0000_2000, 32'd16, 3, 0, 0, 0, 0);
      run_xfer("abort_b1",    4'b0100, 2, 32'h0000_1000, 32'd40, 0, 5, 0, 0, 0);
      run_xfer("ar_timeout",  4'b1000, 3, 32'h0000_3000, 32'd8,  0, 0, 1, 0, 0);
      run_xfer("r_timeout",   4'b0001, 0, 32'h0000_3000, 32'd8,  0, 0, 0, 1, 0);
      run_xfer("reset_data",  4'b0100, 2, 32'h0000_1000, 32'd20, 0, 0, 0, 0, 5);
      run_xfer("after_reset", 4'b0100, 2, 32'h0000_1000, 32'd20, 0, 0, 0, 0, 0);

      for (int n = 0; n < 6; n++) begin
         int          rch;
         logic [31:0] raddr;
         rch   = $urandom_range(0, CH - 1);
         raddr = 32'(($urandom_range(1, 8) << 12) - 4 * $urandom_range(0, 40));
         run_xfer("random", CH'(1 << rch), rch, raddr, 32'($urandom_range(1, 60)), 0, 0, 0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
